sys_array_ctrl: RTL
===================

// Module: sys_array_ctrl
// PURPOSE
//  Sequencer for an ARRAY_SIZE x ARRAY_SIZE grid of sys_array_cell instances.
//  On start it loads weights row by row, then streams num_vec input vectors with
//  diagonal skew, then drains the pipeline and pulses done.
//  Sits between the weight/input buffers and the cell grid; it drives only
//  control and index signals and carries no datapath.
// PARAMETERS
//  ARRAY_SIZE  4   rows/cols of the cell grid (N), >=2
//  CNT_W       8   width of num_vec / in_vec_idx / out_vec_idx
//  PIPE_LAT    2*ARRAY_SIZE-1  cycles from in_rd_en of vector k to out_valid of vector k
// PORTS
//  clk          in   1            clock, rising edge
//  reset        in   1            synchronous, active-high
//  start        in   1            begin a job; accepted only in IDLE
//  abort        in   1            synchronous job cancel
//  num_vec      in   CNT_W        number of input vectors M; sampled when start is accepted
//  weight_load  out  1            weight_load strobe to the cells of row weight_row
//  weight_row   out  $clog2(N)    row currently being loaded
//  in_rd_en     out  1            fetch input vector in_vec_idx into row 0 this cycle
//  in_vec_idx   out  CNT_W        index of vector being fed
//  skew_en      out  N            bit i = row i consumes data this cycle
//  out_valid    out  1            result vector out_vec_idx is at the array output
//  out_vec_idx  out  CNT_W        index of the result vector
//  busy         out  1            job in progress (start ignored)
//  done         out  1            one-cycle completion pulse
// BEHAVIOUR
//  Reset: all outputs 0; FSM=IDLE; delay lines cleared. Takes effect at the next edge, even mid-job.
//  FSM: IDLE -> LOAD_W -> SETTLE -> FEED -> DRAIN -> DONE -> IDLE.
//  Timing: cycle 0 = first cycle after the edge that accepts start (IDLE & start).
//   - LOAD_W, cycles 0..N-1: weight_load=1, weight_row=c.
//   - SETTLE, cycle N: weight_load=0; all other controls idle.
//   - FEED, cycles N+1..N+M: in_rd_en=1, in_vec_idx=0..M-1.
//   - DRAIN, PIPE_LAT cycles: no new in_rd_en.
//   - DONE, cycle N+M+PIPE_LAT+1: done=1 for exactly 1 cycle.
//  busy: 1 from cycle 0 through the DONE cycle inclusive; 0 in IDLE.
//  skew_en[0]=in_rd_en; skew_en[i] = in_rd_en delayed i cycles (shift register).
//  out_valid/out_vec_idx: in_rd_en/in_vec_idx delayed PIPE_LAT cycles.
//  Vectors leave the array in order with no gaps.
//  num_vec latched at start; later changes are ignored until the next job.
//  M=0: SETTLE goes directly to DONE, so done is asserted at cycle N+1.
//   No in_rd_en, skew_en or out_valid is produced.
//  M=2^CNT_W-1 (max): idx counters do not wrap within a job.
//  start while busy: ignored, no effect on the running job.
//  start in the DONE cycle: ignored; accepted only from IDLE.
//  abort (any non-IDLE state): next cycle FSM=IDLE and all outputs 0.
//   Delay lines are flushed and done is not pulsed.
//   abort in IDLE has no effect.
//  abort and start together in IDLE: abort wins; the job is not started.
//  reset has priority over abort and start.
// TESTING
//  T1: N=4, M=3, start pulse -> weight_load cycles 0-3 with weight_row 0,1,2,3;
//      in_rd_en cycles 5-7 (idx 0,1,2); skew_en[3] cycles 8-10;
//      out_valid cycles 12-14 (idx 0,1,2); done cycle 15; busy cycles 0-15.
//  T2: M=0 -> weight_load cycles 0-3, done cycle 5, no in_rd_en or out_valid.
//  T3: start re-pulsed at cycles 2 and 15 of T1 job, num_vec changed to 9 at cycle 2
//      -> timing identical to T1; second job starts only after IDLE.
//  T4: abort at cycle 6 of T1 -> cycle 7 all outputs 0;
//      no out_valid, no done; a new start afterwards reproduces T1.
//  T5: reset asserted at cycle 9 of T1 -> all outputs 0 next cycle;
//      start while reset=1 ignored.
//  T6: back-to-back jobs, start in the first IDLE cycle after done ->
//      second job cycle 0 follows immediately; out_valid count equals M per job.

Source files
------------

// File: rtl/sys_array_ctrl.sv
// Sequencer for an ARRAY_SIZE x ARRAY_SIZE systolic cell grid: weight load, skewed input
// feed, pipeline drain and a one-cycle done pulse. Drives control and index signals only.
module sys_array_ctrl #(
   parameter int unsigned ARRAY_SIZE = 4,
   parameter int unsigned CNT_W      = 8,
   parameter int unsigned PIPE_LAT   = 2 * ARRAY_SIZE - 1
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          start,
   input  logic                          abort,
   input  logic [CNT_W-1:0]              num_vec,
   output logic                          weight_load,
   output logic [$clog2(ARRAY_SIZE)-1:0] weight_row,
   output logic                          in_rd_en,
   output logic [CNT_W-1:0]              in_vec_idx,
   output logic [ARRAY_SIZE-1:0]         skew_en,
   output logic                          out_valid,
   output logic [CNT_W-1:0]              out_vec_idx,
   output logic                          busy,
   output logic                          done
);

   localparam int unsigned RowW = $clog2(ARRAY_SIZE);
   localparam int unsigned PhW  = $clog2(PIPE_LAT + 1);

   typedef enum logic [2:0] {
      StIdle, StLoadW, StSettle, StFeed, StDrain, StDone
   } state_e;

   state_e           state_q, state_d;
   logic [PhW-1:0]   ph_q, ph_d;
   logic [CNT_W-1:0] vec_q, vec_d;
   logic [CNT_W-1:0] num_q, num_d;
   logic             accept;
   logic             flush;

   logic [PIPE_LAT-1:0] rd_pipe_q;
   logic [CNT_W-1:0]    idx_pipe_q [PIPE_LAT];

   // abort beats start in IDLE; abort outside IDLE cancels the job and empties the pipes
   assign accept = (state_q == StIdle) && start && !abort;
   assign flush  = (state_q != StIdle) && abort;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         ph_q    <= '0;
         vec_q   <= '0;
         num_q   <= '0;
      end else begin
         state_q <= state_d;
         ph_q    <= ph_d;
         vec_q   <= vec_d;
         num_q   <= num_d;
      end
   end

   always_comb begin
      state_d = state_q;
      ph_d    = ph_q;
      vec_d   = vec_q;
      num_d   = num_q;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               state_d = StLoadW;
               ph_d    = '0;
               num_d   = num_vec;
            end
         end
         StLoadW: begin
            if (ph_q == PhW'(ARRAY_SIZE - 1)) begin
               state_d = StSettle;
               ph_d    = '0;
            end else begin
               ph_d = ph_q + PhW'(1);
            end
         end
         StSettle: begin
            vec_d   = '0;
            state_d = (num_q == '0) ? StDone : StFeed;
         end
         StFeed: begin
            if (vec_q == num_q - CNT_W'(1)) begin
               state_d = StDrain;
               ph_d    = '0;
            end else begin
               vec_d = vec_q + CNT_W'(1);
            end
         end
         StDrain: begin
            if (ph_q == PhW'(PIPE_LAT - 1)) begin
               state_d = StDone;
            end else begin
               ph_d = ph_q + PhW'(1);
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
      if (flush) begin
         state_d = StIdle;
         ph_d    = '0;
         vec_d   = '0;
      end
   end

   always_comb begin
      weight_load = (state_q == StLoadW);
      weight_row  = weight_load ? ph_q[RowW-1:0] : '0;
      in_rd_en    = (state_q == StFeed);
      in_vec_idx  = in_rd_en ? vec_q : '0;
      busy        = (state_q != StIdle);
      done        = (state_q == StDone);
   end

   // Tap k of the delay line holds in_rd_en / in_vec_idx from k+1 cycles ago
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         rd_pipe_q <= '0;
         for (int i = 0; i < PIPE_LAT; i++) begin
            idx_pipe_q[i] <= '0;
         end
      end else begin
         rd_pipe_q     <= {rd_pipe_q[PIPE_LAT-2:0], in_rd_en};
         idx_pipe_q[0] <= in_vec_idx;
         for (int i = 1; i < PIPE_LAT; i++) begin
            idx_pipe_q[i] <= idx_pipe_q[i-1];
         end
      end
   end

   assign skew_en     = {rd_pipe_q[ARRAY_SIZE-2:0], in_rd_en};
   assign out_valid   = rd_pipe_q[PIPE_LAT-1];
   assign out_vec_idx = idx_pipe_q[PIPE_LAT-1];

endmodule
